// File: rtl/ss_universal_register.sv
// WIDTH-bit universal shift register (hold / shift right / shift left / load)
// with a shift counter that strobes frame_done after every WIDTH shifts.
module ss_universal_register #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [1:0]       mode,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic [CW-1:0]    shift_cnt,
  output logic             frame_done
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("ss_universal_register: WIDTH must be in 2..32");
  end

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  mode_t            mode_e;
  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    cnt_next;
  logic             fd_next;
  logic             is_shift;
  logic             last_shift;

  assign mode_e     = mode_t'(mode);
  assign is_shift   = (mode_e == MODE_SHR) || (mode_e == MODE_SHL);
  assign last_shift = (shift_cnt == CW'(WIDTH - 1));

  always_comb begin
    q_next   = q;
    cnt_next = shift_cnt;
    fd_next  = 1'b0;
    if (ena) begin
      unique case (mode_e)
        MODE_HOLD: ;
        MODE_SHR:  q_next = {ser_in_r, q[WIDTH-1:1]};
        MODE_SHL:  q_next = {q[WIDTH-2:0], ser_in_l};
        MODE_LOAD: begin
          q_next   = par_in;
          cnt_next = '0;
        end
      endcase
      // Both shift directions advance the same frame counter.
      if (is_shift) begin
        if (last_shift) begin
          cnt_next = '0;
          fd_next  = 1'b1;
        end else begin
          cnt_next = shift_cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q          <= '0;
      shift_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      q          <= q_next;
      shift_cnt  <= cnt_next;
      frame_done <= fd_next;
    end
  end

  assign ser_out_r = q[0];
  assign ser_out_l = q[WIDTH-1];

endmodule

// File: tb/tb_ss_universal_register.sv
// Scoreboard bench for ss_universal_register (WIDTH=8): the driver queues the
// hand-computed post-edge state, a negedge monitor pops and compares it.
module tb_ss_universal_register;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [1:0] mode;
  logic       ser_in_r;
  logic       ser_in_l;
  logic [7:0] par_in;
  logic [7:0] q;
  logic       ser_out_r;
  logic       ser_out_l;
  logic [2:0] shift_cnt;
  logic       frame_done;

  typedef struct {
    logic [7:0] q;
    logic [2:0] cnt;
    logic       fd;
    string      name;
  } exp_t;

  exp_t sb[$];
  int unsigned vectors;
  int unsigned miscompares;

  ss_universal_register #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .mode       (mode),
    .ser_in_r   (ser_in_r),
    .ser_in_l   (ser_in_l),
    .par_in     (par_in),
    .q          (q),
    .ser_out_r  (ser_out_r),
    .ser_out_l  (ser_out_l),
    .shift_cnt  (shift_cnt),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected state per clock, checked away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (q !== e.q || shift_cnt !== e.cnt || frame_done !== e.fd ||
          ser_out_r !== e.q[0] || ser_out_l !== e.q[7]) begin
        miscompares++;
        $display("FAIL %s: got q=%h cnt=%0d fd=%b sor=%b sol=%b, want q=%h cnt=%0d fd=%b sor=%b sol=%b",
                 e.name, q, shift_cnt, frame_done, ser_out_r, ser_out_l,
                 e.q, e.cnt, e.fd, e.q[0], e.q[7]);
      end
    end
  end

  task automatic step(input logic r, input logic en, input logic [1:0] m,
                      input logic sr, input logic sl, input logic [7:0] p,
                      input logic [7:0] eq, input logic [2:0] ec,
                      input logic ef, input string nm);
    exp_t e;
    rst      = r;
    ena      = en;
    mode     = m;
    ser_in_r = sr;
    ser_in_l = sl;
    par_in   = p;
    @(posedge clk);
    e.q = eq; e.cnt = ec; e.fd = ef; e.name = nm;
    sb.push_back(e);
    #1;
  endtask

  logic [7:0] t2_q   [8] = '{8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
  logic [7:0] t6a_q  [6] = '{8'h78, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
  logic [7:0] t6b_q  [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
  logic [7:0] t3_q   [3] = '{8'h03, 8'h07, 8'h0F};
  logic [7:0] t5_q   [5] = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07};

  initial begin
    logic [7:0] t;
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; ena = 1'b1; mode = 2'b11;
    ser_in_r = 1'b0; ser_in_l = 1'b0; par_in = 8'hFF;
    #1;

    // 1: reset beats a parallel load
    for (int i = 0; i < 2; i++)
      step(1, 1, 2'b11, 0, 0, 8'hFF, 8'h00, 3'd0, 0, "reset_over_load");

    // 2: load A5, eight right shifts of zero, frame strobe on the last
    step(0, 1, 2'b11, 0, 0, 8'hA5, 8'hA5, 3'd0, 0, "load_a5");
    for (int i = 0; i < 8; i++)
      step(0, 1, 2'b01, 0, 0, 8'h00, t2_q[i], 3'((i + 1) % 8), (i == 7), "shr_a5");
    step(0, 1, 2'b00, 0, 0, 8'h00, 8'h00, 3'd0, 0, "hold_after_frame");

    // 3: load 81, three left shifts of one
    step(0, 1, 2'b11, 0, 0, 8'h81, 8'h81, 3'd0, 0, "load_81");
    for (int i = 0; i < 3; i++)
      step(0, 1, 2'b10, 0, 1, 8'h00, t3_q[i], 3'(i + 1), 0, "shl_81");

    // 4: 24 continuous right shifts of one from zero, strobes at 8/16/24
    step(0, 1, 2'b11, 0, 0, 8'h00, 8'h00, 3'd0, 0, "load_00");
    for (int i = 1; i <= 24; i++) begin
      t = 8'hFF;
      t = t >> i;
      step(0, 1, 2'b01, 1, 0, 8'h00, (i >= 8) ? 8'hFF : ~t, 3'(i % 8),
           (i % 8 == 0), "shr_continuous");
    end

    // 5: five shifts, enable low freezes state, load clears counter
    for (int i = 0; i < 5; i++)
      step(0, 1, 2'b01, 0, 0, 8'h00, t5_q[i], 3'(i + 1), 0, "shr_before_freeze");
    for (int i = 0; i < 3; i++)
      step(0, 0, 2'b01, 1, 1, 8'hAA, 8'h07, 3'd5, 0, "ena_low_freeze");
    step(0, 1, 2'b11, 0, 0, 8'h3C, 8'h3C, 3'd0, 0, "load_3c");

    // 6: partial frame discarded by reset, full frame afterwards
    for (int i = 0; i < 6; i++)
      step(0, 1, 2'b10, 0, 0, 8'h00, t6a_q[i], 3'(i + 1), 0, "shl_partial");
    step(1, 1, 2'b10, 0, 1, 8'h00, 8'h00, 3'd0, 0, "reset_mid_frame");
    for (int i = 0; i < 8; i++)
      step(0, 1, 2'b10, 0, 1, 8'h00, t6b_q[i], 3'((i + 1) % 8), (i == 7), "shl_after_reset");
    step(0, 0, 2'b10, 0, 1, 8'h00, 8'hFF, 3'd0, 0, "strobe_one_cycle");

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
